jh512_result_checker: RTL and testbench

- Scan driver and result consumer for the fully pipelined JH512 core.
- Issues one 128-bit header tail per clock, with an incrementing 32-bit nonce, into the core's data input.
- Tracks each issue through the core's fixed pipeline latency and compares every returned 512-bit hash against a 64-bit target.
- Queues winning ("golden") nonces in a small FIFO with a valid/ready handshake toward the host-side readout logic.

---
 rtl/jh512_pkg.sv | 16 +
 rtl/jh512_gn_fifo.sv | 51 +++++
 rtl/jh512_result_checker.sv | 146 ++++++++++++++
 tb/tb_jh512_result_checker.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jh512_pkg.sv
// Shared constants and FSM state type for the JH512 scan driver.
// Imported by jh512_gn_fifo and jh512_result_checker.
package jh512_pkg;

  localparam int NONCE_W  = 32;
  localparam int HASH_W   = 512;
  localparam int TARGET_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/jh512_gn_fifo.sv
// Synchronous FIFO for golden nonces; push+pop allowed when full.
// Ports: clk, rst, push, pop, din, dout (head), full, empty.
module jh512_gn_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  import jh512_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // a pop frees the slot the same-cycle push lands in
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jh512_result_checker.sv
// JH512 scan driver: issues nonces, checks returned hashes vs target.
// Ports: start/stop/range/tail/target in, data_out to core, hash_in
// from core, busy/done status, gn_* golden FIFO handshake,
// gn_overflow sticky, hashes_done (JH512_SCAN_STATS_EN, else 0).
module jh512_result_checker #(
  parameter int PIPE_LATENCY = 96,
  parameter int FIFO_DEPTH   = 8,
  parameter int NONCE_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic [NONCE_W-1:0]            nonce_start,
  input  logic [NONCE_W-1:0]            nonce_end,
  input  logic [95:0]                   data_tail,
  input  logic [jh512_pkg::TARGET_W-1:0] target,
  output logic [95+NONCE_W:0]           data_out,
  input  logic [jh512_pkg::HASH_W-1:0]  hash_in,
  output logic                          busy,
  output logic                          done,
  output logic                          gn_valid,
  input  logic                          gn_ready,
  output logic [NONCE_W-1:0]            gn_nonce,
  output logic                          gn_overflow,
  output logic [63:0]                   hashes_done
);

  import jh512_pkg::*;

  state_t                  state;
  logic [95:0]             tail_reg;
  logic [NONCE_W-1:0]      nonce_cnt;
  logic [NONCE_W-1:0]      end_reg;
  logic [NONCE_W-1:0]      res_cnt;
  logic [NONCE_W-1:0]      push_nonce;
  logic [TARGET_W-1:0]     target_reg;
  logic [PIPE_LATENCY-1:0] vsr;
  logic [PIPE_LATENCY-1:0] vsr_nx;
  logic                    start_ok;
  logic                    res_valid;
  logic                    match;
  logic                    push_q;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic                    unused_hash;

  assign start_ok  = start && (state == IDLE);
  assign vsr_nx    = (vsr << 1) |
                     PIPE_LATENCY'(state == SCAN);
  assign res_valid = vsr[PIPE_LATENCY-1];
  assign match     = hash_in[HASH_W-1 -: TARGET_W] <= target_reg;
  assign data_out  = {tail_reg, nonce_cnt};
  assign pop       = gn_valid && gn_ready;
  assign gn_valid  = !empty;

  assign unused_hash = ^hash_in[HASH_W-TARGET_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      tail_reg    <= '0;
      nonce_cnt   <= '0;
      end_reg     <= '0;
      target_reg  <= '0;
      vsr         <= '0;
      res_cnt     <= '0;
      push_q      <= 1'b0;
      push_nonce  <= '0;
      gn_overflow <= 1'b0;
    end else begin
      vsr        <= vsr_nx;
      done       <= 1'b0;
      push_q     <= res_valid && match;
      push_nonce <= res_cnt;
      if (res_valid) res_cnt <= res_cnt + 1'b1;
      if (push_q && full && !pop) gn_overflow <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            tail_reg    <= data_tail;
            nonce_cnt   <= nonce_start;
            res_cnt     <= nonce_start;
            end_reg     <= nonce_end;
            target_reg  <= target;
            gn_overflow <= 1'b0;
            busy        <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (nonce_cnt == end_reg || stop) begin
            state <= DRAIN;
          end else begin
            nonce_cnt <= nonce_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // leave as the last in-flight result is consumed
          if (vsr_nx == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  jh512_gn_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (pop),
    .din   (push_nonce),
    .dout  (gn_nonce),
    .full  (full),
    .empty (empty)
  );

`ifdef JH512_SCAN_STATS_EN
  logic [63:0] hash_cnt;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      hash_cnt <= '0;
    end else if (res_valid && hash_cnt != '1) begin
      hash_cnt <= hash_cnt + 1'b1;
    end
  end

  assign hashes_done = hash_cnt;
`else
  assign hashes_done = '0;
`endif

endmodule

// File: tb/tb_jh512_result_checker.sv
// Bench for jh512_result_checker: modelled core pipeline plus
// directed and random scans checked against a nonce-list model.
module tb_jh512_result_checker;

  localparam int PL = 4;
  localparam int FD = 2;
`ifdef JH512_SCAN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic [95:0]  data_tail;
  logic [63:0]  target;
  logic [127:0] data_out;
  logic [511:0] hash_in;
  logic         busy;
  logic         done;
  logic         gn_valid;
  logic         gn_ready = 1'b0;
  logic [31:0]  gn_nonce;
  logic         gn_overflow;
  logic [63:0]  hashes_done;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int n_iss;
  logic [31:0] salt = 32'h0;
  logic [127:0] pipe [PL];
  logic [31:0] got [$];
  logic [31:0] exp_q [$];

  jh512_result_checker #(
    .PIPE_LATENCY (PL),
    .FIFO_DEPTH   (FD),
    .NONCE_W      (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .nonce_start (nonce_start),
    .nonce_end   (nonce_end),
    .data_tail   (data_tail),
    .target      (target),
    .data_out    (data_out),
    .hash_in     (hash_in),
    .busy        (busy),
    .done        (done),
    .gn_valid    (gn_valid),
    .gn_ready    (gn_ready),
    .gn_nonce    (gn_nonce),
    .gn_overflow (gn_overflow),
    .hashes_done (hashes_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] top_of(input logic [31:0] n);
    case (mode)
      0: return {32'h0, n};
      1: return (n == 32'h22) ? 64'h100 : 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {n * 32'h9E37_79B1, n ^ salt};
    endcase
  endfunction

  // core model: fixed PL-stage pipe, hash derived from the nonce
  always @(posedge clk) begin
    pipe[0] <= data_out;
    for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
  end

  assign hash_in = {top_of(pipe[PL-1][31:0]), 448'(pipe[PL-1])};

  always @(negedge clk) begin
    if (gn_valid === 1'b1 && gn_ready === 1'b1) got.push_back(gn_nonce);
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected golden nonces: issued range, optionally cut by stop
  task automatic build(input logic [31:0] ns, input logic [31:0] ne,
                       input int stop_at, input logic [63:0] tg);
    logic [31:0] n;
    exp_q.delete();
    n_iss = int'(ne - ns) + 1;
    if (stop_at >= 0 && stop_at + 1 < n_iss) n_iss = stop_at + 1;
    for (int i = 0; i < n_iss; i++) begin
      n = ns + 32'(i);
      if (top_of(n) <= tg) exp_q.push_back(n);
    end
  endtask

  task automatic cmp_q(input string tag);
    chk(tag, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk(tag, got[i], exp_q[i]);
    got.delete();
  endtask

  task automatic drain();
    gn_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_empty", gn_valid, 1'b0);
  endtask

  task automatic scan(input logic [31:0] ns, input logic [31:0] ne,
                      input logic [63:0] tg, input int stop_at,
                      input int ign_at, input int rst_at,
                      input bit rdy, input int rdy_pulse,
                      output int dcyc);
    nonce_start = ns;
    nonce_end   = ne;
    target      = tg;
    data_tail   = {$urandom, $urandom, $urandom};
    gn_ready    = rdy;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dcyc  = -1;
    for (int c = 0; c < 400; c++) begin
      stop     = (c == stop_at);
      start    = (c == ign_at);
      rst      = (c == rst_at);
      gn_ready = rdy || (c == rdy_pulse);
      if (c == 0) begin
        chk("issue0", data_out, {data_tail, ns});
        chk("ovf_clr", gn_overflow, 1'b0);
        chk("busy_scan", busy, 1'b1);
      end
      if (done === 1'b1) begin
        dcyc = c;
        break;
      end
      if (rst_at >= 0 && c == rst_at + 1) begin
        dcyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    stop     = 1'b0;
    start    = 1'b0;
    rst      = 1'b0;
    gn_ready = rdy;
  endtask

  task automatic post_done();
    @(posedge clk);
    #1;
    chk("done_pulse", done, 1'b0);
    chk("busy_after", busy, 1'b0);
  endtask

  initial begin
    int d;
    logic [31:0] ns;
    logic [63:0] tg;
    int cnt;

    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    nonce_start = '0;
    nonce_end = '0;
    data_tail = '0;
    target = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_gnv", gn_valid, 1'b0);
    chk("rst_ovf", gn_overflow, 1'b0);
    chk("rst_dout", data_out, 128'h0);
    chk("rst_hd", hashes_done, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // all match, echo hash
    mode = 0;
    tg = '1;
    scan(32'h10, 32'h13, tg, -1, -1, -1, 1'b1, -1, d);
    build(32'h10, 32'h13, -1, tg);
    chk("t1_done_cyc", d, n_iss + PL);
    post_done();
    drain();
    cmp_q("t1_list");

    // single match at the threshold
    mode = 1;
    tg = 64'h100;
    scan(32'h20, 32'h2F, tg, -1, -1, -1, 1'b1, -1, d);
    build(32'h20, 32'h2F, -1, tg);
    chk("t2_done_cyc", d, n_iss + PL);
    post_done();
    drain();
    cmp_q("t2_list");
    chk("t2_ovf", gn_overflow, 1'b0);

    // wrapping range
    mode = 0;
    tg = '1;
    scan(32'hFFFF_FFFE, 32'h1, tg, -1, -1, -1, 1'b1, -1, d);
    build(32'hFFFF_FFFE, 32'h1, -1, tg);
    chk("t3_done_cyc", d, n_iss + PL);
    post_done();
    drain();
    cmp_q("t3_list");

    // overflow with no consumer: first FD kept
    scan(32'h50, 32'h54, tg, -1, -1, -1, 1'b0, -1, d);
    build(32'h50, 32'h54, -1, tg);
    chk("t4_done_cyc", d, n_iss + PL);
    post_done();
    chk("t4_ovf", gn_overflow, 1'b1);
    chk("t4_head", gn_nonce, 32'h50);
    chk("t4_nopop", got.size(), 0);
    while (exp_q.size() > FD) void'(exp_q.pop_back());
    drain();
    cmp_q("t4_list");
    chk("t4_sticky", gn_overflow, 1'b1);

    // pop while full with a push in the same cycle
    // 3rd result pushes at cycle PL+3 while FIFO holds two
    gn_ready = 1'b0;
    scan(32'h60, 32'h64, tg, -1, -1, -1, 1'b0, PL + 3, d);
    chk("t4b_done_cyc", d, 5 + PL);
    post_done();
    exp_q.delete();
    exp_q.push_back(32'h60);
    cmp_q("t4b_popped");
    chk("t4b_ovf", gn_overflow, 1'b1);
    exp_q.push_back(32'h61);
    exp_q.push_back(32'h62);
    void'(exp_q.pop_front());
    drain();
    cmp_q("t4b_list");

    // stop on third SCAN cycle; start during DRAIN ignored
    scan(32'h40, 32'h4F, tg, 2, 4, -1, 1'b1, -1, d);
    build(32'h40, 32'h4F, 2, tg);
    chk("t5_done_cyc", d, n_iss + PL);
    post_done();
    drain();
    cmp_q("t5_list");

    // reset mid-DRAIN with a match pending
    scan(32'h70, 32'h73, tg, -1, -1, PL + 1, 1'b1, -1, d);
    chk("t6_rst_cyc", d, PL + 2);
    chk("t6_busy", busy, 1'b0);
    chk("t6_hd", hashes_done, 64'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_gnv", gn_valid, 1'b0);
    chk("t6_none", got.size(), 0);
    got.delete();

    // stats count
    scan(32'h80, 32'h89, tg, -1, -1, -1, 1'b1, -1, d);
    build(32'h80, 32'h89, -1, tg);
    chk("t7_done_cyc", d, n_iss + PL);
    chk("t7_hd", hashes_done, STATS ? 64'd10 : 64'd0);
    post_done();
    drain();
    cmp_q("t7_list");

    // random ranges, hashes and targets
    mode = 2;
    for (int r = 0; r < 4; r++) begin
      salt = $urandom;
      ns = $urandom;
      cnt = $urandom_range(6, 20);
      tg = {$urandom, $urandom};
      scan(ns, ns + 32'(cnt - 1), tg, -1, -1, -1, 1'b1, -1, d);
      build(ns, ns + 32'(cnt - 1), -1, tg);
      chk("rnd_done_cyc", d, n_iss + PL);
      chk("rnd_hd", hashes_done, STATS ? 64'(cnt) : 64'd0);
      post_done();
      drain();
      cmp_q("rnd_list");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
